note_player: RTL and testbench
==============================

// Module: note_player
// PURPOSE
//  Downstream consumer and controller of the sine sample reader. Holds the current note's
//  step size and duration, and pulses generate_next once per codec sample request.
//  Captures the reader's sample after its fixed 3-cycle latency and applies a linear
//  attack/release gain ramp to avoid clicks. Emits one scaled sample per request.
//  Sits between the song/note sequencer (upstream) and the codec/mixer (downstream).
// PARAMETERS
//  GAIN_W     6   gain fraction bits; gain runs 0..2^GAIN_W (GAIN_W+1-bit register)
//  DUR_W      6   width of the note duration, in beats
//  TIMEOUT    8   max cycles to wait for sample_ready_in before forcing a zero sample
// PORTS
//  clk              in   1      system clock
//  reset            in   1      asynchronous, active-high; clears all state
//  play_enable      in   1      0 = pause: requests answered with zero, counters hold
//  load_new_note    in   1      1-cycle pulse: latch step_size_in/duration_in, restart note
//  step_size_in     in   20     phase increment for the new note
//  duration_in      in   DUR_W  note length in beats; 0 = rest (no tone, immediate done)
//  beat             in   1      1-cycle tempo tick; decrements the duration counter
//  sample_req       in   1      1-cycle pulse from codec: one output sample wanted
//  sample_in        in   16     signed sample from the sine reader
//  sample_ready_in  in   1      reader sample valid (3 cycles after generate_next)
//  step_size        out  20     registered step size to the sine reader
//  generate_next    out  1      1-cycle pulse: reader advances phase and produces a sample
//  sample_out       out  16     signed, gain-scaled sample to codec
//  sample_valid     out  1      1-cycle pulse; sample_out is valid this cycle
//  note_done        out  1      1-cycle pulse when the release ramp reaches zero (or on a rest)
//  busy             out  1      high in any state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE; step_size, sample_out, gain, duration count = 0; all pulses low.
//  States: IDLE, ATTACK, SUSTAIN, RELEASE (note phase) x SAMPLE sub-FSM {READY, WAIT}.
//  load_new_note (any state, play_enable=1): latch step and duration, gain=0.
//   duration_in != 0 -> ATTACK. duration_in == 0 -> note_done pulses next cycle, stay IDLE.
//   A load during WAIT takes effect for the note phase only; the pending sample completes.
//  beat (ATTACK/SUSTAIN, play_enable=1): dur_cnt-1; when it reaches 0 -> RELEASE.
//   load_new_note and beat in the same cycle: load wins, beat ignored.
//  Gain steps once per emitted sample. ATTACK: +1, -> SUSTAIN when it hits 2^GAIN_W.
//   RELEASE: -1; on reaching 0 -> note_done pulse, -> IDLE. No overflow or underflow, ever.
//   A beat expiry during ATTACK enters RELEASE from the current gain.
//  sample_req in READY, non-IDLE, play_enable=1: generate_next=1 next cycle, -> WAIT.
//   In WAIT, capture on sample_ready_in:
//   sample_out <= (sample_in * gain) >>> GAIN_W (signed, 16x(GAIN_W+1) product, arith shift)
//   registered; sample_valid pulses the following cycle; gain updates; -> READY.
//  Nominal latency sample_req -> sample_valid = 5 cycles (1 + 3 reader + 1).
//  sample_req in IDLE or play_enable=0: no generate_next; sample_out=0, sample_valid next cycle.
//  sample_req while in WAIT: ignored (dropped, no queue).
//  sample_ready_in while in READY: ignored.
//  TIMEOUT cycles in WAIT without sample_ready_in: sample_out=0, sample_valid pulse, -> READY;
//   gain unchanged.
//  Asynchronous reset mid-note or mid-WAIT aborts immediately; a late sample_ready_in
//   after reset is ignored.
// TESTING
//  1. Reset, req with no note -> sample_valid 1 cycle later, sample_out=0, generate_next never high.
//  2. Load step=0x01000, dur=2; req -> generate_next at +1; reader model returns 0x4000 at +4
//     -> sample_out=0x0000 (gain 0) at +5; 2nd sample uses gain 1 -> 0x4000>>>6 = 0x0100.
//  3. 70 reqs with sample_in=0x4000 -> gain saturates at 64; sample_out=0x4000; state SUSTAIN.
//  4. 2 beats -> RELEASE; gain steps 64..0 per sample; note_done pulses once; busy drops.
//  5. load and beat same cycle; sample_req during WAIT; dur=0 rest -> load wins; the 2nd req
//     is dropped; rest gives note_done next cycle.
//  6. Reader model never asserts ready -> zero sample after TIMEOUT=8; reset asserted in WAIT
//     -> all outputs 0.

Source files
------------

// File: rtl/note_player.sv
// Note player: drives the sine reader once per codec request and scales each
// returned sample by a linear attack/sustain/release gain envelope.
module note_player #(
  parameter int GAIN_W  = 6,
  parameter int DUR_W   = 6,
  parameter int TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               play_enable,
  input  logic               load_new_note,
  input  logic [19:0]        step_size_in,
  input  logic [DUR_W-1:0]   duration_in,
  input  logic               beat,
  input  logic               sample_req,
  input  logic signed [15:0] sample_in,
  input  logic               sample_ready_in,
  output logic [19:0]        step_size,
  output logic               generate_next,
  output logic signed [15:0] sample_out,
  output logic               sample_valid,
  output logic               note_done,
  output logic               busy
);

  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int PROD_W = 16 + GAIN_W + 2;
  localparam logic [GAIN_W:0]  GAIN_MAX = {1'b1, {GAIN_W{1'b0}}};
  localparam logic [GAIN_W:0]  GAIN_TOP = GAIN_MAX - 1;
  localparam logic [GAIN_W:0]  GAIN_ONE = 1;
  localparam logic [DUR_W-1:0] DUR_ONE  = 1;
  localparam logic [TO_W-1:0]  TO_ONE   = 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} phase_t;
  typedef enum logic {SMP_READY, SMP_WAIT} smp_t;

  phase_t             phase, phase_n;
  smp_t               smp, smp_n;
  logic [19:0]        step_n;
  logic [DUR_W-1:0]   dur_cnt, dur_n;
  logic [GAIN_W:0]    gain, gain_n;
  logic [TO_W-1:0]    to_cnt, to_n;
  logic signed [15:0] sample_n;
  logic               valid_n, gen_n, done_n;
  logic               capture;
  logic signed [PROD_W-1:0] product;

  assign busy = (phase != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase         <= IDLE;
      smp           <= SMP_READY;
      step_size     <= '0;
      dur_cnt       <= '0;
      gain          <= '0;
      to_cnt        <= '0;
      sample_out    <= '0;
      sample_valid  <= 1'b0;
      generate_next <= 1'b0;
      note_done     <= 1'b0;
    end else begin
      phase         <= phase_n;
      smp           <= smp_n;
      step_size     <= step_n;
      dur_cnt       <= dur_n;
      gain          <= gain_n;
      to_cnt        <= to_n;
      sample_out    <= sample_n;
      sample_valid  <= valid_n;
      generate_next <= gen_n;
      note_done     <= done_n;
    end
  end

  always_comb begin
    phase_n  = phase;
    smp_n    = smp;
    step_n   = step_size;
    dur_n    = dur_cnt;
    gain_n   = gain;
    to_n     = to_cnt;
    sample_n = sample_out;
    valid_n  = 1'b0;
    gen_n    = 1'b0;
    done_n   = 1'b0;
    capture  = (smp == SMP_WAIT) && sample_ready_in;
    // Gain is zero-extended before the signed multiply so 2^GAIN_W stays positive.
    product  = PROD_W'(sample_in) * PROD_W'($signed({1'b0, gain}));

    case (smp)
      SMP_READY: begin
        if (sample_req) begin
          if (phase != IDLE && play_enable) begin
            gen_n = 1'b1;
            smp_n = SMP_WAIT;
            to_n  = '0;
          end else begin
            sample_n = '0;
            valid_n  = 1'b1;
          end
        end
      end
      SMP_WAIT: begin
        if (sample_ready_in) begin
          sample_n = 16'(product >>> GAIN_W);
          valid_n  = 1'b1;
          smp_n    = SMP_READY;
        end else if (to_cnt == TO_LAST) begin
          sample_n = '0;
          valid_n  = 1'b1;
          smp_n    = SMP_READY;
        end else begin
          to_n = to_cnt + TO_ONE;
        end
      end
      default: smp_n = SMP_READY;
    endcase

    // A load overrides both the beat and the per-sample gain step of this cycle.
    if (load_new_note && play_enable) begin
      step_n = step_size_in;
      dur_n  = duration_in;
      gain_n = '0;
      if (duration_in != '0) begin
        phase_n = ATTACK;
      end else begin
        phase_n = IDLE;
        done_n  = 1'b1;
      end
    end else begin
      if (capture) begin
        case (phase)
          ATTACK: begin
            if (gain >= GAIN_TOP) begin
              gain_n  = GAIN_MAX;
              phase_n = SUSTAIN;
            end else begin
              gain_n = gain + GAIN_ONE;
            end
          end
          RELEASE: begin
            if (gain <= GAIN_ONE) begin
              gain_n  = '0;
              phase_n = IDLE;
              done_n  = 1'b1;
            end else begin
              gain_n = gain - GAIN_ONE;
            end
          end
          default: ;
        endcase
      end
      if (beat && play_enable && (phase == ATTACK || phase == SUSTAIN)) begin
        if (dur_cnt <= DUR_ONE) begin
          dur_n   = '0;
          phase_n = RELEASE;
        end else begin
          dur_n = dur_cnt - DUR_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: a 3-cycle sine reader model feeds samples back while a
// scoreboard checks every emitted sample value and its request-to-valid latency.
module tb_note_player;

  localparam int DUR_W = 6;

  logic               clk = 1'b0;
  logic               reset;
  logic               play_enable;
  logic               load_new_note;
  logic [19:0]        step_size_in;
  logic [DUR_W-1:0]   duration_in;
  logic               beat;
  logic               sample_req;
  logic [15:0]        sample_in = '0;
  logic               sample_ready_in = 1'b0;
  logic [19:0]        step_size;
  logic               generate_next;
  logic [15:0]        sample_out;
  logic               sample_valid;
  logic               note_done;
  logic               busy;

  note_player #(.GAIN_W(6), .DUR_W(DUR_W), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .play_enable(play_enable), .load_new_note(load_new_note),
    .step_size_in(step_size_in), .duration_in(duration_in), .beat(beat),
    .sample_req(sample_req), .sample_in(sample_in), .sample_ready_in(sample_ready_in),
    .step_size(step_size), .generate_next(generate_next), .sample_out(sample_out),
    .sample_valid(sample_valid), .note_done(note_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    int          issue;
    int          latency;
  } sb_t;

  typedef struct {
    logic [15:0] sample;
    logic [15:0] expected;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[8];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gn_count = 0;
  int done_count = 0;
  logic        reader_on = 1'b1;
  logic [15:0] reader_sample = 16'h4000;
  logic [3:0]  pipe = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [15:0] scale(input logic [15:0] s, input int g);
    int p;
    p = int'($signed(s)) * g;
    p = p >>> 6;
    return p[15:0];
  endfunction

  // Reader model (ready 3 cycles after generate_next) plus output monitor.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      pipe = {pipe[2:0], generate_next};
      sample_ready_in = pipe[3] && reader_on;
      sample_in = sample_ready_in ? reader_sample : 16'h5a5a;
      if (generate_next) gn_count++;
      if (note_done) done_count++;
      if (sample_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_valid: got sample_out 0x%0h, expected no sample", sample_out);
        end else begin
          e = sb.pop_front();
          checkOutput("sample_out", {16'h0, sample_out}, {16'h0, e.value});
          checkOutput("latency", cyc - e.issue, e.latency);
        end
      end
    end
  end

  task automatic applyStimulus(input logic load, input logic [19:0] step,
                               input logic [DUR_W-1:0] dur, input logic bt);
    @(negedge clk);
    load_new_note = load;
    step_size_in  = step;
    duration_in   = dur;
    beat          = bt;
    @(negedge clk);
    load_new_note = 1'b0;
    beat          = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL sample_timeout: %0d samples outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic request(input logic [15:0] exp, input int lat);
    @(negedge clk);
    sb.push_back('{exp, cyc, lat});
    sample_req = 1'b1;
    @(negedge clk);
    sample_req = 1'b0;
    wait_drain(20);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int mg;
    int g0;
    reset = 1'b1;
    play_enable = 1'b1;
    load_new_note = 1'b0;
    step_size_in = '0;
    duration_in = '0;
    beat = 1'b0;
    sample_req = 1'b0;

    vecs[0] = '{16'h4000, 16'h0000};
    vecs[1] = '{16'h4000, 16'h0100};
    vecs[2] = '{16'h8000, 16'hFC00};
    vecs[3] = '{16'h7FFF, 16'h05FF};
    vecs[4] = '{16'hFFFF, 16'hFFFF};
    vecs[5] = '{16'h0040, 16'h0005};
    vecs[6] = '{16'hFFC0, 16'hFFFA};
    vecs[7] = '{16'h1234, 16'h01FD};

    // 1: reset state and request with no note
    repeat (2) @(negedge clk);
    checkOutput("rst_step_size", {12'h0, step_size}, 32'h0);
    checkOutput("rst_sample_out", {16'h0, sample_out}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_valid", {31'h0, sample_valid}, 32'h0);
    checkOutput("rst_gen", {31'h0, generate_next}, 32'h0);
    checkOutput("rst_done", {31'h0, note_done}, 32'h0);
    reset = 1'b0;
    request(16'h0000, 1);
    checkOutput("idle_no_gen", gn_count, 0);

    // 2: load and first attack samples from the vector table
    applyStimulus(1'b1, 20'h01000, 6'd2, 1'b0);
    checkOutput("load_step", {12'h0, step_size}, 32'h01000);
    checkOutput("load_busy", {31'h0, busy}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      reader_sample = vecs[i].sample;
      request(vecs[i].expected, 5);
    end
    checkOutput("attack_gen_count", gn_count, 8);

    // 3: ramp to full gain and sustain
    reader_sample = 16'h4000;
    mg = 8;
    for (int i = 0; i < 62; i++) begin
      request(scale(16'h4000, mg), 5);
      if (mg < 64) mg++;
    end
    checkOutput("sustain_busy", {31'h0, busy}, 32'h1);

    // 4: two beats expire the note, release ramps down to zero
    applyStimulus(1'b0, 20'h0, 6'd0, 1'b1);
    applyStimulus(1'b0, 20'h0, 6'd0, 1'b1);
    checkOutput("release_busy", {31'h0, busy}, 32'h1);
    checkOutput("release_no_done", done_count, 0);
    for (int g = 64; g >= 1; g--) request(scale(16'h4000, g), 5);
    checkOutput("release_done_once", done_count, 1);
    checkOutput("release_idle", {31'h0, busy}, 32'h0);
    request(16'h0000, 1);

    // 5a: load with a simultaneous beat; the beat must be ignored
    applyStimulus(1'b1, 20'h02000, 6'd3, 1'b1);
    checkOutput("load2_step", {12'h0, step_size}, 32'h02000);
    applyStimulus(1'b0, 20'h0, 6'd0, 1'b1);
    applyStimulus(1'b0, 20'h0, 6'd0, 1'b1);
    request(16'h0000, 5);
    request(16'h0100, 5);
    checkOutput("load_wins_busy", {31'h0, busy}, 32'h1);
    applyStimulus(1'b0, 20'h0, 6'd0, 1'b1);
    request(16'h0200, 5);
    request(16'h0100, 5);
    checkOutput("early_release_done", done_count, 2);
    checkOutput("early_release_idle", {31'h0, busy}, 32'h0);

    // 5b: second request during WAIT is dropped
    applyStimulus(1'b1, 20'h03000, 6'd5, 1'b0);
    g0 = gn_count;
    @(negedge clk);
    sb.push_back('{16'h0000, cyc, 5});
    sample_req = 1'b1;
    @(negedge clk);
    sample_req = 1'b0;
    @(negedge clk);
    sample_req = 1'b1;
    @(negedge clk);
    sample_req = 1'b0;
    wait_drain(20);
    repeat (8) @(negedge clk);
    checkOutput("dropped_req_gen", gn_count - g0, 1);

    // 5c: rest load during ATTACK gives note_done next cycle
    applyStimulus(1'b1, 20'h0, 6'd0, 1'b0);
    checkOutput("rest_done", {31'h0, note_done}, 32'h1);
    checkOutput("rest_idle", {31'h0, busy}, 32'h0);
    @(negedge clk);
    checkOutput("rest_done_pulse", {31'h0, note_done}, 32'h0);
    checkOutput("rest_done_count", done_count, 3);

    // 6a: reader never answers -> zero sample after timeout, gain unchanged
    applyStimulus(1'b1, 20'h04000, 6'd5, 1'b0);
    reader_on = 1'b0;
    request(16'h0000, 9);
    reader_on = 1'b1;
    request(16'h0000, 5);
    request(16'h0100, 5);
    play_enable = 1'b0;
    request(16'h0000, 1);
    play_enable = 1'b1;

    // 6b: reset asserted mid-WAIT; the late reader answer is ignored
    @(negedge clk);
    sample_req = 1'b1;
    @(negedge clk);
    sample_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("wait_rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("wait_rst_step", {12'h0, step_size}, 32'h0);
    checkOutput("wait_rst_sample", {16'h0, sample_out}, 32'h0);
    checkOutput("wait_rst_gen", {31'h0, generate_next}, 32'h0);
    checkOutput("wait_rst_valid", {31'h0, sample_valid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("post_rst_sample", {16'h0, sample_out}, 32'h0);
    checkOutput("post_rst_busy", {31'h0, busy}, 32'h0);
    request(16'h0000, 1);
    checkOutput("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
